// File: rtl/sfx_sched.sv
// Sound-effect scheduler: latches one-shot requests and grants the single tone voice by fixed priority.
// Optional build macro SFX_PREEMPT_EN lets a higher-priority request cut off the effect now playing.
module sfx_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned FW   = 16,
  parameter int unsigned LW   = 12,
  parameter int unsigned GAP  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*FW-1:0]   req_freq,
  input  logic [NREQ*LW-1:0]   req_len,
  output logic [NREQ-1:0]      gnt,
  output logic [FW-1:0]        freq,
  output logic                 gate,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [FW-1:0]   freq_q, freq_d;
  logic            gate_q, gate_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;

  logic [IW-1:0]   sel_idx;
  logic [FW-1:0]   sel_freq;
  logic [LW-1:0]   sel_len;
  logic            preempt_c;

  // Lowest set index wins; index 0 is the highest priority.
  function automatic logic [IW-1:0] lowest_idx(input logic [NREQ-1:0] v);
    logic found;
    lowest_idx = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (v[i] && !found) begin
        lowest_idx = IW'(i);
        found      = 1'b1;
      end
    end
  endfunction

  assign sel_idx  = lowest_idx(pending_q);
  assign sel_freq = req_freq[32'(sel_idx) * FW +: FW];
  assign sel_len  = req_len[32'(sel_idx) * LW +: LW];

  // gnt_q - 1 masks every index of higher priority than the one now playing.
`ifdef SFX_PREEMPT_EN
  assign preempt_c = |(pending_q & (gnt_q - NREQ'(1)));
`else
  assign preempt_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      gnt_q     <= '0;
      freq_q    <= '0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      freq_q    <= freq_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Next-state and output logic; a grant (fresh or preempting) always takes the lowest pending index.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    freq_d  = freq_q;
    gate_d  = gate_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    clr     = '0;

    case (state_q)
      S_IDLE: begin
        if (ena && (|pending_q)) begin
          clr[sel_idx] = 1'b1;
          state_d      = S_PLAY;
          gnt_d        = NREQ'(1) << sel_idx;
          freq_d       = sel_freq;
          gate_d       = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = (sel_len == '0) ? LW'(1) : sel_len;
        end
      end

      S_PLAY: begin
        if (ena) begin
          if (preempt_c) begin
            // The cut-off effect is dropped: no done, no gap, gate stays high.
            clr[sel_idx] = 1'b1;
            gnt_d        = NREQ'(1) << sel_idx;
            freq_d       = sel_freq;
            cnt_d        = (sel_len == '0) ? LW'(1) : sel_len;
          end else if (cnt_q == LW'(1)) begin
            done_d = 1'b1;
            gate_d = 1'b0;
            gnt_d  = '0;
            if (GAP == 0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = S_GAP;
              gcnt_d  = GW'(GAP);
            end
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end

      S_GAP: begin
        if (ena) begin
          if (gcnt_q == GW'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            gcnt_d = gcnt_q - GW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A request arriving on the clearing clk survives, so the effect replays later.
  assign pending_d = (pending_q & ~clr) | req;

  assign gnt  = gnt_q;
  assign freq = freq_q;
  assign gate = gate_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sfx_sched.sv
// Scoreboard bench for sfx_sched: expected effects are queued at request time and checked at each done.
module tb_sfx_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned FW   = 16;
  localparam int unsigned LW   = 12;
  localparam int unsigned GAP  = 4;
  localparam int          SP   = 4;
  localparam int          BUDGET = 3000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ena;
  logic [NREQ-1:0]      req;
  logic [NREQ*FW-1:0]   req_freq;
  logic [NREQ*LW-1:0]   req_len;
  logic [NREQ-1:0]      gnt;
  logic [FW-1:0]        freq;
  logic                 gate;
  logic                 busy;
  logic                 done;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [FW-1:0]   freq;
    int              len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // observation state kept by the monitor
  int              done_cnt = 0;
  int              ecnt = 0;
  logic [NREQ-1:0] last_gnt = '0;
  logic [NREQ-1:0] st_gnt = '0;
  logic [NREQ-1:0] d_gnt = '0;
  logic [FW-1:0]   d_freq = '0;
  int              d_len = 0;
  bit              multihot = 1'b0;
  int              div = 0;

  sfx_sched #(.NREQ(NREQ), .FW(FW), .LW(LW), .GAP(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .req      (req),
    .req_freq (req_freq),
    .req_len  (req_len),
    .gnt      (gnt),
    .freq     (freq),
    .gate     (gate),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // sample strobe: one clk high every SP clks
  initial begin
    ena = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ena = (div == SP - 1);
      div = (div == SP - 1) ? 0 : div + 1;
    end
  end

  // effect monitor: strobes counted while gate is high, captured at each done
  always @(negedge clk) begin
    if (reset) begin
      ecnt     = 0;
      last_gnt = '0;
    end else begin
      if (gnt != '0 && gnt != last_gnt) begin
        ecnt   = 0;
        st_gnt = gnt;
      end
      if (gate && ena) ecnt++;
      if ($countones(gnt) > 1) multihot = 1'b1;
      if (done) begin
        done_cnt++;
        d_gnt  = st_gnt;
        d_freq = freq;
        d_len  = ecnt;
      end
      last_gnt = gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_eff(input int idx, input logic [FW-1:0] f, input logic [LW-1:0] l);
    req_freq[idx*FW +: FW] = f;
    req_len[idx*LW +: LW]  = l;
  endtask

  task automatic push_exp(input logic [NREQ-1:0] g, input logic [FW-1:0] f, input int l);
    exp_t e;
    e.gnt  = g;
    e.freq = f;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [NREQ-1:0] m);
    @(posedge clk);
    #1 req = m;
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (gnt == '0 && n < 4 * SP) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt == '0) begin
      errors++;
      $display("FAIL %s grant timeout: gnt=%b after %0d clk, required nonzero within %0d", name, gnt, n, 4 * SP);
    end
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s done timeout: no done in %0d clk, required one", name, BUDGET);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected done: gnt=%b, required no effect", name, d_gnt);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (d_gnt !== e.gnt) begin
        errors++;
        $display("FAIL %s gnt: got %b required %b", name, d_gnt, e.gnt);
      end
      checks++;
      if (d_freq !== e.freq) begin
        errors++;
        $display("FAIL %s freq: got %h required %h", name, d_freq, e.freq);
      end
      checks++;
      if (d_len !== e.len) begin
        errors++;
        $display("FAIL %s gate strobes: got %0d required %0d", name, d_len, e.len);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b1;
    req   = '0;
    base  = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({gnt, gate, busy, done} !== '0 || freq !== '0) begin
      errors++;
      $display("FAIL reset outputs: gnt=%b gate=%b busy=%b done=%b freq=%h, required all 0", gnt, gate, busy, done, freq);
    end
    #1 reset = 1'b0;
    repeat (3 * SP) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: done pulses=%0d busy=%b, required 0 and 0", done_cnt - base, busy);
    end
  endtask

  task automatic test_single();
    int c = 0;
    int n = 0;
    set_eff(1, 16'h0400, 12'd3);
    push_exp(4'b0010, 16'h0400, 3);
    pulse(4'b0010);
    wait_grant("single");
    checks++;
    if (gnt !== 4'b0010 || freq !== 16'h0400 || gate !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single grant: gnt=%b freq=%h gate=%b busy=%b, required 0010 0400 1 1", gnt, freq, gate, busy);
    end
    wait_done("single");
    while (n < BUDGET) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      if (ena) c++;
    end
    checks++;
    if (c != int'(GAP)) begin
      errors++;
      $display("FAIL single gap: busy fell after %0d strobes, required %0d", c, GAP);
    end
  endtask

  task automatic test_priority();
    multihot = 1'b0;
    set_eff(0, 16'h1000, 12'd2);
    set_eff(2, 16'h0300, 12'd3);
    push_exp(4'b0001, 16'h1000, 2);
    push_exp(4'b0100, 16'h0300, 3);
    pulse(4'b0101);
    wait_done("prio_first");
    wait_done("prio_second");
    checks++;
    if (multihot !== 1'b0) begin
      errors++;
      $display("FAIL prio onehot: multi-hot gnt seen=%b, required 0", multihot);
    end
  endtask

  task automatic test_preempt();
    int c = 0;
    int n = 0;
    int base;
    base = done_cnt;
    set_eff(2, 16'h0222, 12'd100);
    set_eff(0, 16'h0111, 12'd5);
`ifdef SFX_PREEMPT_EN
    push_exp(4'b0001, 16'h0111, 5);
`else
    push_exp(4'b0100, 16'h0222, 100);
    push_exp(4'b0001, 16'h0111, 5);
`endif
    pulse(4'b0100);
    wait_grant("preempt");
    while (c < 10 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (ena) c++;
    end
    pulse(4'b0001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ena && n < 4 * SP);
    @(posedge clk);
    #1;
    checks++;
`ifdef SFX_PREEMPT_EN
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL preempt switch: gnt=%b required 0001", gnt);
    end
`else
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL preempt hold: gnt=%b required 0100", gnt);
    end
    wait_done("preempt_low");
`endif
    wait_done("preempt_high");
    wait_idle();
    checks++;
`ifdef SFX_PREEMPT_EN
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL preempt dones: got %0d required 1", done_cnt - base);
    end
`else
    if (done_cnt - base != 2) begin
      errors++;
      $display("FAIL preempt dones: got %0d required 2", done_cnt - base);
    end
`endif
  endtask

  task automatic test_zero_len();
    set_eff(3, 16'hABCD, 12'd0);
    push_exp(4'b1000, 16'hABCD, 1);
    pulse(4'b1000);
    wait_done("zero_len");
  endtask

  task automatic test_reset_mid();
    int base;
    set_eff(1, 16'h0555, 12'd50);
    pulse(4'b0010);
    wait_grant("reset_mid");
    pulse(4'b1000);
    base = done_cnt;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, gate, busy, done} !== '0 || freq !== '0) begin
      errors++;
      $display("FAIL reset_mid async: gnt=%b gate=%b busy=%b done=%b freq=%h, required all 0", gnt, gate, busy, done, freq);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10 * SP) @(posedge clk);
    #1;
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || done_cnt != base) begin
      errors++;
      $display("FAIL reset_mid after: gnt=%b busy=%b dones=%0d, required 0 0 0", gnt, busy, done_cnt - base);
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_freq = '0;
    req_len  = '0;
    test_reset();
    test_single();
    wait_idle();
    test_priority();
    wait_idle();
    test_preempt();
    wait_idle();
    test_zero_len();
    wait_idle();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: %0d entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
